// File: rtl/blit_wrbuf.sv
// Blitter write-back buffer: drops suppressed phrases, merges or byte-enables
// the rest, queues them in a small FIFO and issues them over a req/ack port.
module blit_wrbuf #(
   parameter int DEPTH = 2,
   parameter int MERGE = 1
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [20:0] wr_addr,
   input  logic [63:0] wr_data,
   input  logic [63:0] dstd,
   input  logic [7:0]  dbinh_n,
   input  logic        nowrite,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [20:0] mem_addr,
   output logic [63:0] mem_data,
   output logic [7:0]  mem_be,
   input  logic        cnt_clr,
   output logic [15:0] wr_count,
   output logic [15:0] skip_count,
   output logic        idle
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t state, state_nxt;

   logic [AW:0]  wr_ptr, rd_ptr;
   logic [20:0]  fifo_addr [DEPTH];
   logic [63:0]  fifo_data [DEPTH];
   logic [7:0]   fifo_be   [DEPTH];

   logic         fifo_empty, fifo_full;
   logic         accept, skip, push, pop;
   logic [63:0]  merged_data, entry_data;
   logic [7:0]   entry_be;

   // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign wr_ready = !fifo_full;
   assign accept   = wr_valid && wr_ready;
   assign skip     = nowrite || (dbinh_n == 8'h00);
   assign push     = accept && !skip;

   always_comb begin
      merged_data = wr_data;
      for (int i = 0; i < 8; i++) begin
         if (!dbinh_n[i]) merged_data[8*i +: 8] = dstd[8*i +: 8];
      end
   end

   assign entry_data = (MERGE != 0) ? merged_data : wr_data;
   assign entry_be   = (MERGE != 0) ? 8'hFF : dbinh_n;

   always_ff @(posedge sys_clk) begin
      if (push) begin
         fifo_addr[wr_ptr[AW-1:0]] <= wr_addr;
         fifo_data[wr_ptr[AW-1:0]] <= entry_data;
         fifo_be[wr_ptr[AW-1:0]]   <= entry_be;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Pop whenever the output register is free or is being retired by an ack,
   // which gives back-to-back issue with mem_req held high.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         mem_addr <= '0;
         mem_data <= '0;
         mem_be   <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            mem_addr <= fifo_addr[rd_ptr[AW-1:0]];
            mem_data <= fifo_data[rd_ptr[AW-1:0]];
            mem_be   <= fifo_be[rd_ptr[AW-1:0]];
         end
      end
   end

   assign mem_req = (state == S_REQ);
   assign idle    = (state == S_IDLE) && fifo_empty;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         wr_count   <= '0;
         skip_count <= '0;
      end else if (cnt_clr) begin
         wr_count   <= '0;
         skip_count <= '0;
      end else begin
         if (mem_req && mem_ack && wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
         if (accept && skip && skip_count != 16'hFFFF)
            skip_count <= skip_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_blit_wrbuf.sv
// Self-checking bench for blit_wrbuf: one merge-mode and one byte-enable-mode
// instance driven in lockstep, checked against a transaction-queue model.
module tb_blit_wrbuf;

   localparam int DEPTH = 2;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic [20:0] wr_addr;
   logic [63:0] wr_data;
   logic [63:0] dstd;
   logic [7:0]  dbinh_n;
   logic        nowrite;
   logic        mem_ack;
   logic        cnt_clr;

   logic        a_ready, a_req, a_idle;
   logic [20:0] a_addr;
   logic [63:0] a_data;
   logic [7:0]  a_be;
   logic [15:0] a_wr_count, a_skip_count;

   logic        b_ready, b_req, b_idle;
   logic [20:0] b_addr;
   logic [63:0] b_data;
   logic [7:0]  b_be;
   logic [15:0] b_wr_count, b_skip_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [20:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } entry_t;

   entry_t      q_a[$];
   entry_t      q_b[$];
   logic [15:0] exp_wr, exp_skip;

   always #5 sys_clk = ~sys_clk;

   blit_wrbuf #(.DEPTH(DEPTH), .MERGE(1)) u_merge (
      .sys_clk(sys_clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(a_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .dstd(dstd), .dbinh_n(dbinh_n),
      .nowrite(nowrite), .mem_req(a_req), .mem_ack(mem_ack), .mem_addr(a_addr),
      .mem_data(a_data), .mem_be(a_be), .cnt_clr(cnt_clr), .wr_count(a_wr_count),
      .skip_count(a_skip_count), .idle(a_idle)
   );

   blit_wrbuf #(.DEPTH(DEPTH), .MERGE(0)) u_be (
      .sys_clk(sys_clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(b_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .dstd(dstd), .dbinh_n(dbinh_n),
      .nowrite(nowrite), .mem_req(b_req), .mem_ack(mem_ack), .mem_addr(b_addr),
      .mem_data(b_data), .mem_be(b_be), .cnt_clr(cnt_clr), .wr_count(b_wr_count),
      .skip_count(b_skip_count), .idle(b_idle)
   );

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [63:0] merge_phrase(input logic [63:0] src, input logic [63:0] dst,
                                                input logic [7:0] inh_n);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = inh_n[i] ? src[8*i +: 8] : dst[8*i +: 8];
      return r;
   endfunction

   task automatic check_counts(input string tag, input logic [15:0] wr, input logic [15:0] sk);
      check({tag, "_a_wr"}, a_wr_count, wr);
      check({tag, "_b_wr"}, b_wr_count, wr);
      check({tag, "_a_skip"}, a_skip_count, sk);
      check({tag, "_b_skip"}, b_skip_count, sk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req"}, {a_req, b_req}, 2'b00);
      check({tag, "_ready"}, {a_ready, b_ready}, 2'b11);
      check({tag, "_idle"}, {a_idle, b_idle}, 2'b11);
      check({tag, "_a_out"}, {a_addr, a_data, a_be}, '0);
      check({tag, "_b_out"}, {b_addr, b_data, b_be}, '0);
      check_counts(tag, 16'h0, 16'h0);
   endtask

   task automatic apply_stimulus(input logic v, input logic [20:0] ad, input logic [63:0] d,
                                 input logic [63:0] dd, input logic [7:0] inh, input logic nw);
      wr_valid = v;
      wr_addr  = ad;
      wr_data  = d;
      dstd     = dd;
      dbinh_n  = inh;
      nowrite  = nw;
   endtask

   // One clock of the reference model: retire handshakes against the queue
   // head, enqueue or count accepted phrases, then compare counters.
   task automatic model_cycle();
      entry_t e;
      logic   acc, hs_a, hs_b;
      acc  = wr_valid && a_ready;
      hs_a = a_req && mem_ack;
      hs_b = b_req && mem_ack;
      if (hs_a) begin
         check("rnd_a_pending", q_a.size() != 0, 1'b1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("rnd_a_entry", {a_addr, a_data, a_be}, e);
         end
      end
      if (hs_b) begin
         check("rnd_b_pending", q_b.size() != 0, 1'b1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("rnd_b_entry", {b_addr, b_data, b_be}, e);
         end
      end
      if (acc) begin
         if (nowrite || dbinh_n == 8'h00) begin
            if (exp_skip != 16'hFFFF) exp_skip++;
         end else begin
            q_a.push_back('{wr_addr, merge_phrase(wr_data, dstd, dbinh_n), 8'hFF});
            q_b.push_back('{wr_addr, wr_data, dbinh_n});
         end
      end
      if (hs_a && exp_wr != 16'hFFFF) exp_wr++;
      if (cnt_clr) begin
         exp_wr   = 16'h0;
         exp_skip = 16'h0;
      end
      step();
      check_counts("rnd", exp_wr, exp_skip);
   endtask

   initial begin
      logic [20:0] p_addr[4];
      logic [63:0] d;
      int          nacc, nhs;
      logic        hs, acc, done;

      reset   = 1'b1;
      mem_ack = 1'b0;
      cnt_clr = 1'b0;
      apply_stimulus(1'b0, '0, '0, '0, 8'h00, 1'b0);
      #1;
      check_reset_state("rst0");
      step();
      step();
      reset = 1'b0;
      step();
      check_reset_state("rst1");

      $display("[TB] merge with inhibits, ack held high");
      mem_ack = 1'b1;
      apply_stimulus(1'b1, 21'h12345, {8{8'h11}}, {8{8'hAA}}, 8'h0F, 1'b0);
      step();
      wr_valid = 1'b0;
      check("t1_req_after_accept", a_req, 1'b0);
      check("t1_not_idle", a_idle, 1'b0);
      step();
      check("t1_req", {a_req, b_req}, 2'b11);
      check("t1_a_out", {a_addr, a_data, a_be}, {21'h12345, 64'hAAAAAAAA11111111, 8'hFF});
      check("t1_b_out", {b_addr, b_data, b_be}, {21'h12345, {8{8'h11}}, 8'h0F});
      step();
      check("t1_done", {a_req, a_idle, b_req, b_idle}, 4'b0101);
      check_counts("t1", 16'd1, 16'd0);

      $display("[TB] byte-enable pattern A5");
      d = {$urandom, $urandom};
      apply_stimulus(1'b1, 21'h0ABCD, d, 64'h0123456789ABCDEF, 8'hA5, 1'b0);
      step();
      wr_valid = 1'b0;
      step();
      check("t2_b_out", {b_addr, b_data, b_be}, {21'h0ABCD, d, 8'hA5});
      check("t2_a_out", {a_addr, a_data, a_be},
            {21'h0ABCD, merge_phrase(d, 64'h0123456789ABCDEF, 8'hA5), 8'hFF});
      step();
      check_counts("t2", 16'd2, 16'd0);

      $display("[TB] counter clear and skip rules");
      mem_ack = 1'b0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_counts("clr", 16'd0, 16'd0);
      apply_stimulus(1'b1, 21'h1, {8{8'h55}}, '0, 8'hFF, 1'b1);
      step();
      check_counts("skip1", 16'd0, 16'd1);
      apply_stimulus(1'b1, 21'h2, {8{8'h66}}, '0, 8'h00, 1'b0);
      step();
      wr_valid = 1'b0;
      check_counts("skip2", 16'd0, 16'd2);
      step();
      check("skip_no_req", {a_req, b_req, a_idle, b_idle}, 4'b0011);

      $display("[TB] capacity DEPTH+1 with ack low");
      for (int i = 0; i < 4; i++) p_addr[i] = 21'h100 + 21'(i);
      apply_stimulus(1'b1, p_addr[0], 64'h10, '0, 8'hFF, 1'b0);
      step();
      check("cap_e1", {a_ready, a_req}, 2'b10);
      wr_addr = p_addr[1];
      step();
      check("cap_e2", {a_ready, a_req, a_addr}, {2'b11, p_addr[0]});
      wr_addr = p_addr[2];
      step();
      check("cap_e3_full", {a_ready, b_ready, a_req}, 3'b001);
      wr_addr = p_addr[3];
      step();
      check("cap_e4_hold", {a_ready, a_req, a_addr}, {2'b01, p_addr[0]});
      mem_ack = 1'b1;
      step();
      check("cap_e5", {a_ready, a_req, a_addr}, {2'b11, p_addr[1]});
      step();
      wr_valid = 1'b0;
      check("cap_e6", {a_req, a_addr}, {1'b1, p_addr[2]});
      step();
      check("cap_e7", {a_req, a_addr, b_addr}, {1'b1, p_addr[3], p_addr[3]});
      step();
      check("cap_e8", {a_req, a_idle}, 2'b01);
      check_counts("cap", 16'd4, 16'd2);

      $display("[TB] randomized traffic against queue model");
      cnt_clr = 1'b1;
      step();
      cnt_clr  = 1'b0;
      exp_wr   = 16'h0;
      exp_skip = 16'h0;
      for (int n = 0; n < 400; n++) begin
         apply_stimulus($urandom_range(0, 3) != 0, 21'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom},
                        ($urandom_range(0, 5) == 0) ? 8'h00 :
                        ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                        $urandom_range(0, 7) == 0);
         mem_ack = 1'($urandom_range(0, 1));
         cnt_clr = $urandom_range(0, 31) == 0;
         model_cycle();
      end
      wr_valid = 1'b0;
      cnt_clr  = 1'b0;
      mem_ack  = 1'b1;
      for (int n = 0; n < 8; n++) model_cycle();
      check("rnd_drained", {q_a.size() == 0, q_b.size() == 0, a_idle, b_idle}, 4'b1111);

      $display("[TB] reset while requests outstanding");
      mem_ack = 1'b0;
      apply_stimulus(1'b1, 21'h77, 64'h1, '0, 8'hFF, 1'b0);
      step();
      step();
      step();
      wr_valid = 1'b0;
      check("mid_pre", {a_req, a_ready}, 2'b10);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("mid_rst");
      mem_ack = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         check("mid_after", {a_req, b_req, a_idle, b_idle}, 4'b0011);
         check_counts("mid_after", 16'd0, 16'd0);
      end

      $display("[TB] wr_count saturation and clear");
      apply_stimulus(1'b1, 21'h3, 64'h5, '0, 8'hFF, 1'b0);
      mem_ack = 1'b1;
      nacc    = 0;
      nhs     = 0;
      done    = 1'b0;
      for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
         hs      = a_req && mem_ack;
         acc     = wr_valid && a_ready;
         cnt_clr = hs && (nhs == 65536);
         step();
         cnt_clr = 1'b0;
         if (acc) nacc++;
         if (hs) nhs++;
         wr_valid = (nacc < 65537);
         if (hs && nhs == 65535) check_counts("sat_reach", 16'hFFFF, 16'h0);
         if (hs && nhs == 65536) check_counts("sat_hold", 16'hFFFF, 16'h0);
         if (hs && nhs == 65537) begin
            check_counts("sat_clr", 16'h0, 16'h0);
            done = 1'b1;
         end
      end
      check("sat_completed", done, 1'b1);
      wr_valid = 1'b0;
      step();
      check("sat_idle", {a_idle, b_idle}, 2'b11);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
